// File: rtl/axis_tb_pkg.sv
// Shared state encoding, default frame geometry and width helper for the
// AXI-Stream loopback tester.
package axis_tb_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StDelay,
        StSend,
        StReceive,
        StReport
    } lb_state_e;

    localparam int unsigned DefaultWords   = 8;
    localparam int unsigned DefaultTimeout = 1024;

    // Smallest r with 2**r >= value.
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_pattern_gen.sv
// Frame pattern source and checker: word k of a frame is base + k, and an
// observed word is compared against it.
module axis_pattern_gen #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdxWidth  = 4
) (
    input  logic [DataWidth-1:0] base_i,
    input  logic [IdxWidth-1:0]  index_i,
    input  logic [DataWidth-1:0] actual_i,
    output logic [DataWidth-1:0] expected_o,
    output logic                 match_o
);

    assign expected_o = base_i + DataWidth'(index_i);
    assign match_o    = (actual_i == expected_o);

endmodule

// File: rtl/axis_loopback_tester.sv
// Sends one incrementing-pattern frame on the master stream, then checks the
// frame returned on the slave stream and reports mismatches, framing and timeout.
module axis_loopback_tester
    import axis_tb_pkg::*;
#(
    parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned C_S_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned NUMBER_OF_WORDS      = DefaultWords,
    parameter int unsigned C_M_START_COUNT      = 32,
    parameter int unsigned C_TIMEOUT            = DefaultTimeout
) (
    input  logic                                AXIS_ACLK,
    input  logic                                AXIS_ARESET,
    input  logic                                start,
    input  logic [C_M_AXIS_TDATA_WIDTH-1:0]     seed,
    output logic                                M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
    output logic                                M_AXIS_TLAST,
    input  logic                                M_AXIS_TREADY,
    input  logic                                S_AXIS_TVALID,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   S_AXIS_TSTRB,
    input  logic                                S_AXIS_TLAST,
    output logic                                S_AXIS_TREADY,
    output logic                                busy,
    output logic                                done,
    output logic                                pass,
    output logic [clogb2(NUMBER_OF_WORDS):0]    err_count,
    output logic [3:0]                          led
);

    localparam int unsigned IdxW     = clogb2(NUMBER_OF_WORDS) + 1;
    localparam int unsigned DelayW   = clogb2(C_M_START_COUNT) + 1;
    localparam int unsigned TimeoutW = clogb2(C_TIMEOUT) + 1;

    localparam logic [IdxW-1:0]     LastIdx     = IdxW'(NUMBER_OF_WORDS - 1);
    localparam logic [IdxW-1:0]     ErrMax      = IdxW'(NUMBER_OF_WORDS);
    localparam logic [DelayW-1:0]   DelayLast   = DelayW'(C_M_START_COUNT - 1);
    localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(C_TIMEOUT - 1);

    lb_state_e                       state_q;
    logic [C_M_AXIS_TDATA_WIDTH-1:0] seed_q;
    logic [IdxW-1:0]                 beat_idx_q;
    logic [DelayW-1:0]               delay_cnt_q;
    logic [TimeoutW-1:0]             timeout_cnt_q;
    logic                            frame_err_q;
    logic                            timeout_err_q;

    logic [IdxW-1:0]                 gen_idx;
    logic [C_M_AXIS_TDATA_WIDTH-1:0] gen_word;
    logic                            rx_match;
    logic                            rx_last_beat;
    logic                            unused_strb;

    assign unused_strb   = ^S_AXIS_TSTRB;
    assign M_AXIS_TSTRB  = '1;
    assign led           = {busy, pass, frame_err_q, timeout_err_q};
    assign rx_last_beat  = (beat_idx_q == LastIdx);

    // Index of the word the generator must present this cycle: the first word
    // while delaying, the word after the current one while sending.
    always_comb begin
        gen_idx = beat_idx_q;
        if (state_q == StDelay) begin
            gen_idx = '0;
        end else if (state_q == StSend) begin
            gen_idx = beat_idx_q + IdxW'(1);
        end
    end

    axis_pattern_gen #(
        .DataWidth (C_M_AXIS_TDATA_WIDTH),
        .IdxWidth  (IdxW)
    ) u_pattern_gen (
        .base_i     (seed_q),
        .index_i    (gen_idx),
        .actual_i   (S_AXIS_TDATA),
        .expected_o (gen_word),
        .match_o    (rx_match)
    );

    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            state_q       <= StIdle;
            seed_q        <= '0;
            beat_idx_q    <= '0;
            delay_cnt_q   <= '0;
            timeout_cnt_q <= '0;
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TDATA  <= '0;
            M_AXIS_TLAST  <= 1'b0;
            S_AXIS_TREADY <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        seed_q        <= seed;
                        beat_idx_q    <= '0;
                        delay_cnt_q   <= '0;
                        err_count     <= '0;
                        frame_err_q   <= 1'b0;
                        timeout_err_q <= 1'b0;
                        pass          <= 1'b0;
                        busy          <= 1'b1;
                        state_q       <= StDelay;
                    end
                end
                StDelay: begin
                    if (delay_cnt_q == DelayLast) begin
                        M_AXIS_TVALID <= 1'b1;
                        M_AXIS_TDATA  <= gen_word;
                        M_AXIS_TLAST  <= (gen_idx == LastIdx);
                        state_q       <= StSend;
                    end else begin
                        delay_cnt_q <= delay_cnt_q + DelayW'(1);
                    end
                end
                StSend: begin
                    // TVALID is always high here, so TREADY alone means a transfer.
                    if (M_AXIS_TREADY) begin
                        if (M_AXIS_TLAST) begin
                            M_AXIS_TVALID <= 1'b0;
                            M_AXIS_TLAST  <= 1'b0;
                            S_AXIS_TREADY <= 1'b1;
                            beat_idx_q    <= '0;
                            timeout_cnt_q <= '0;
                            state_q       <= StReceive;
                        end else begin
                            beat_idx_q   <= gen_idx;
                            M_AXIS_TDATA <= gen_word;
                            M_AXIS_TLAST <= (gen_idx == LastIdx);
                        end
                    end
                end
                StReceive: begin
                    if (S_AXIS_TVALID) begin
                        timeout_cnt_q <= '0;
                        if (!rx_match && (err_count != ErrMax)) begin
                            err_count <= err_count + IdxW'(1);
                        end
                        if (S_AXIS_TLAST || rx_last_beat) begin
                            frame_err_q   <= (S_AXIS_TLAST != rx_last_beat);
                            S_AXIS_TREADY <= 1'b0;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                            state_q       <= StReport;
                        end else begin
                            beat_idx_q <= beat_idx_q + IdxW'(1);
                        end
                    end else if (timeout_cnt_q == TimeoutLast) begin
                        timeout_err_q <= 1'b1;
                        S_AXIS_TREADY <= 1'b0;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        state_q       <= StReport;
                    end else begin
                        timeout_cnt_q <= timeout_cnt_q + TimeoutW'(1);
                    end
                end
                StReport: begin
                    pass    <= (err_count == '0) && !frame_err_q && !timeout_err_q;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_loopback_tester.sv
// Directed bench for axis_loopback_tester: drives frames, loops the response
// back (optionally corrupted or mis-framed) and checks outputs against constants.
module tb_axis_loopback_tester;

    localparam int N          = 8;
    localparam int StartCount = 32;
    localparam int Timeout    = 1024;

    logic        AXIS_ACLK = 1'b0;
    logic        AXIS_ARESET;
    logic        start;
    logic [31:0] seed;
    logic        M_AXIS_TVALID;
    logic [31:0] M_AXIS_TDATA;
    logic [3:0]  M_AXIS_TSTRB;
    logic        M_AXIS_TLAST;
    logic        M_AXIS_TREADY;
    logic        S_AXIS_TVALID;
    logic [31:0] S_AXIS_TDATA;
    logic [3:0]  S_AXIS_TSTRB;
    logic        S_AXIS_TLAST;
    logic        S_AXIS_TREADY;
    logic        busy;
    logic        done;
    logic        pass;
    logic [3:0]  err_count;
    logic [3:0]  led;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 AXIS_ACLK = ~AXIS_ACLK;

    axis_loopback_tester dut (
        .AXIS_ACLK     (AXIS_ACLK),
        .AXIS_ARESET   (AXIS_ARESET),
        .start         (start),
        .seed          (seed),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TSTRB  (M_AXIS_TSTRB),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .S_AXIS_TVALID (S_AXIS_TVALID),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .S_AXIS_TSTRB  (S_AXIS_TSTRB),
        .S_AXIS_TLAST  (S_AXIS_TLAST),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .led           (led)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge AXIS_ACLK);
        #1;
    endtask

    // Pulse start, optionally poke start again mid-delay, and measure the delay.
    task automatic start_frame(input logic [31:0] s, input bit poke);
        int n;
        start = 1'b1;
        seed  = s;
        tick();
        start = 1'b0;
        seed  = '0;
        check_eq("busy_after_start", busy, 1);
        n = 0;
        while (!M_AXIS_TVALID && n < 200) begin
            if (poke && n == 5) begin
                start = 1'b1;
                seed  = 32'h0000_9999;
            end else begin
                start = 1'b0;
            end
            tick();
            n++;
        end
        start = 1'b0;
        check_eq("delay_cycles", n, StartCount);
    endtask

    task automatic send_phase(input logic [31:0] s, input bit stall);
        logic [31:0] words [N];
        logic        lasts [N];
        int          got;
        int          c;
        logic        held;
        logic [31:0] hd;
        logic        hl;
        got  = 0;
        c    = 0;
        held = 1'b0;
        hd   = '0;
        hl   = 1'b0;
        while (got < N && c < 200) begin
            M_AXIS_TREADY = stall ? (c % 2 == 0) : 1'b1;
            if (held) begin
                check_eq("stall_valid", M_AXIS_TVALID, 1);
                check_eq("stall_data", M_AXIS_TDATA, hd);
                check_eq("stall_last", M_AXIS_TLAST, hl);
            end
            held = M_AXIS_TVALID && !M_AXIS_TREADY;
            hd   = M_AXIS_TDATA;
            hl   = M_AXIS_TLAST;
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                words[got] = M_AXIS_TDATA;
                lasts[got] = M_AXIS_TLAST;
                got++;
            end
            tick();
            c++;
        end
        M_AXIS_TREADY = 1'b0;
        check_eq("tx_beats", got, N);
        for (int i = 0; i < got; i++) begin
            check_eq($sformatf("tx_data%0d", i), words[i], s + 32'(i));
            check_eq($sformatf("tx_last%0d", i), lasts[i], (i == N - 1));
        end
        check_eq("tx_valid_drop", M_AXIS_TVALID, 0);
        check_eq("rx_ready_entry", S_AXIS_TREADY, 1);
    endtask

    // Drive nbeats response words; ca/cb select corrupted words (-1 for none).
    task automatic respond(input logic [31:0] s, input int nbeats, input int last_at,
                           input int ca, input logic [31:0] va,
                           input int cb, input logic [31:0] vb);
        for (int k = 0; k < nbeats; k++) begin
            check_eq($sformatf("rx_ready%0d", k), S_AXIS_TREADY, 1);
            S_AXIS_TVALID = 1'b1;
            S_AXIS_TDATA  = (k == ca) ? va : (k == cb) ? vb : s + 32'(k);
            S_AXIS_TLAST  = (k == last_at);
            tick();
        end
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
        S_AXIS_TDATA  = '0;
    endtask

    task automatic finish_frame(input logic [3:0] exp_err, input logic exp_frame,
                                input logic exp_timeout, input logic exp_pass);
        check_eq("done_pulse", done, 1);
        check_eq("busy_report", busy, 0);
        check_eq("err_count", err_count, exp_err);
        check_eq("frame_err", led[1], exp_frame);
        check_eq("timeout_err", led[0], exp_timeout);
        tick();
        check_eq("done_clear", done, 0);
        check_eq("pass", pass, exp_pass);
        check_eq("led", led, {1'b0, exp_pass, exp_frame, exp_timeout});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        AXIS_ARESET   = 1'b1;
        start         = 1'b0;
        seed          = '0;
        M_AXIS_TREADY = 1'b0;
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TDATA  = '0;
        S_AXIS_TSTRB  = 4'hF;
        S_AXIS_TLAST  = 1'b0;
        repeat (3) tick();
        check_eq("rst_tvalid", M_AXIS_TVALID, 0);
        check_eq("rst_tdata", M_AXIS_TDATA, 0);
        check_eq("rst_tready_s", S_AXIS_TREADY, 0);
        check_eq("rst_led", led, 0);
        check_eq("rst_err_count", err_count, 0);
        check_eq("tstrb", M_AXIS_TSTRB, 4'hF);
        AXIS_ARESET = 1'b0;
        tick();

        // Clean loopback.
        start_frame(32'h100, 1'b0);
        send_phase(32'h100, 1'b0);
        respond(32'h100, N, N - 1, -1, 0, -1, 0);
        finish_frame(4'd0, 1'b0, 1'b0, 1'b1);
        check_eq("led_pass", led, 4'b0100);

        // Transmit stalls on alternate cycles; a stray start mid-delay is ignored.
        start_frame(32'h180, 1'b1);
        send_phase(32'h180, 1'b1);
        respond(32'h180, N, N - 1, -1, 0, -1, 0);
        finish_frame(4'd0, 1'b0, 1'b0, 1'b1);

        // Two corrupted words.
        start_frame(32'h200, 1'b0);
        send_phase(32'h200, 1'b0);
        respond(32'h200, N, N - 1, 3, 32'h0000_DEAD, 6, 32'h0000_BEEF);
        finish_frame(4'd2, 1'b0, 1'b0, 1'b0);

        // Early TLAST on word 4.
        start_frame(32'h280, 1'b0);
        send_phase(32'h280, 1'b0);
        respond(32'h280, 5, 4, -1, 0, -1, 0);
        finish_frame(4'd0, 1'b1, 1'b0, 1'b0);

        // Missing TLAST on word 7.
        start_frame(32'h2C0, 1'b0);
        send_phase(32'h2C0, 1'b0);
        respond(32'h2C0, N, -1, -1, 0, -1, 0);
        finish_frame(4'd0, 1'b1, 1'b0, 1'b0);

        // No response at all.
        start_frame(32'h300, 1'b0);
        send_phase(32'h300, 1'b0);
        n = 0;
        while (!led[0] && n < 2000) begin
            tick();
            n++;
        end
        check_eq("timeout_cycles", n, Timeout);
        finish_frame(4'd0, 1'b0, 1'b1, 1'b0);

        // Reset during a stall on beat 2.
        start_frame(32'h400, 1'b0);
        n = 0;
        M_AXIS_TREADY = 1'b1;
        for (int c = 0; c < 50 && n < 2; c++) begin
            if (M_AXIS_TVALID) n++;
            tick();
        end
        M_AXIS_TREADY = 1'b0;
        tick();
        tick();
        check_eq("stall_beat2_data", M_AXIS_TDATA, 32'h402);
        check_eq("stall_beat2_valid", M_AXIS_TVALID, 1);
        AXIS_ARESET = 1'b1;
        tick();
        AXIS_ARESET = 1'b0;
        check_eq("mid_rst_tvalid", M_AXIS_TVALID, 0);
        check_eq("mid_rst_tdata", M_AXIS_TDATA, 0);
        check_eq("mid_rst_tlast", M_AXIS_TLAST, 0);
        check_eq("mid_rst_tready_s", S_AXIS_TREADY, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_done", done, 0);
        check_eq("mid_rst_pass", pass, 0);
        check_eq("mid_rst_err", err_count, 0);
        check_eq("mid_rst_led", led, 0);
        tick();
        check_eq("post_rst_idle_busy", busy, 0);
        check_eq("post_rst_idle_done", done, 0);

        // Pattern wraps past 2^32.
        start_frame(32'hFFFF_FFFE, 1'b0);
        send_phase(32'hFFFF_FFFE, 1'b0);
        respond(32'hFFFF_FFFE, N, N - 1, -1, 0, -1, 0);
        finish_frame(4'd0, 1'b0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
